gpio_in: RTL and testbench
==========================

GPIO_IN -- requirements
Module: gpio_in

Interface
REQ-001 Parameter WIDTH, default 32, number of input pins and the data word width.
REQ-002 Parameter SYNC_STAGES, default 2, number of flip-flops in the input synchronizer chain (minimum 2).
REQ-003 Parameter TICK_DIV, default 1000, number of clk cycles between debounce sample ticks (minimum 2).
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous reset, active-low; sampled only on the rising edge of clk.
REQ-006 Port pins  input  WIDTH  asynchronous external inputs.
REQ-007 Port sel  input  1  bus access strobe, one access per asserted cycle.
REQ-008 Port we  input  1  write enable, qualified by sel.
REQ-009 Port addr  input  2  word register index.
REQ-010 Port wdata  input  WIDTH  write data.
REQ-011 Port rdata  output  WIDTH  registered read data.
REQ-012 Port irq  output  1  level interrupt to the cpu.

Function
REQ-013 Each pin SHALL pass through a SYNC_STAGES-deep synchronizer before any other logic uses it.
REQ-014 A prescaler SHALL count 0..TICK_DIV-1 and wrap to 0. It SHALL assert a one-cycle tick on the wrap.
REQ-015 On each tick, each bit SHALL shift its synchronized value into a 3-bit sample history.
REQ-016 DATA[i] SHALL take the new value only when all 3 history bits agree and differ from DATA[i]. Otherwise DATA[i] SHALL hold.
REQ-017 A 0->1 change of DATA[i] with RISE_EN[i]=1 SHALL set STATUS[i] in the same cycle as the DATA update.
REQ-018 A 1->0 change of DATA[i] with FALL_EN[i]=1 SHALL set STATUS[i] in the same cycle as the DATA update.
REQ-019 Register map, indexed by addr:
  - 0 = DATA, read-only; writes are ignored.
  - 1 = RISE_EN, read/write.
  - 2 = FALL_EN, read/write.
  - 3 = STATUS, write-1-to-clear.
REQ-020 A write (sel=1, we=1) SHALL update the addressed register at the next clock edge.
REQ-021 A read (sel=1, we=0) SHALL present the addressed register on rdata in the following cycle. This is a latency of exactly 1.
REQ-022 rdata SHALL hold its last value when sel=0.
REQ-023 A read of STATUS SHALL NOT clear it.
REQ-024 If an edge-set and a W1C clear of the same STATUS bit occur in the same cycle, the set SHALL win.
REQ-025 irq SHALL be registered and equal to OR-reduction of STATUS, delayed by one cycle.
REQ-026 Changing RISE_EN or FALL_EN SHALL NOT alter pending STATUS bits.
REQ-027 A pulse that lasts fewer than 3 consecutive ticks SHALL NOT change DATA.

Reset
REQ-028 While reset=0 at a clock edge, the following SHALL be set to zero:
  - prescaler, synchronizers, sample histories;
  - DATA, RISE_EN, FALL_EN, STATUS;
  - rdata, irq.
REQ-029 Reset asserted mid-debounce or with STATUS pending SHALL discard all progress; no edge SHALL be reported for pins that are already high when reset is released.
REQ-030 Immediately after reset release, a pin held high SHALL cause DATA[i] to rise after 3 ticks. STATUS SHALL set only if RISE_EN[i] was written to 1 beforehand.

Structure
REQ-031 Register index constants (DATA, RISE_EN, FALL_EN, STATUS) SHALL live in the shared package used by the cpu address decoder.
REQ-032 The per-bit synchronizer plus 3-sample debounce SHALL be one sub-module, gpio_debounce, instantiated WIDTH times. The prescaler tick SHALL be shared across all instances.

Verification
REQ-033 Read-back: with TICK_DIV=4, reset, then write RISE_EN=0x0000000F. A read of addr 1 -> rdata=0x0000000F one cycle later. A read of addr 0 -> 0.
REQ-034 Rise: with RISE_EN[0]=1, hold pins=0x1. DATA=0x1 within SYNC_STAGES+3*TICK_DIV+1 cycles; STATUS=0x1; irq=1 one cycle after STATUS.
REQ-035 Glitch: a pins[3] high pulse of 2*TICK_DIV cycles -> DATA[3] stays 0, and STATUS and irq stay 0.
REQ-036 Fall with clear race: with FALL_EN[0]=1, drop pins[0] while writing STATUS=0x1 in the cycle DATA[0] falls -> STATUS[0]=1 remains. A later W1C of 0x1 -> STATUS=0 and irq=0 one cycle after.
REQ-037 Reset mid-operation: with STATUS=0x1 and pins=0xFF, assert reset for 1 cycle:
  - all registers, rdata and irq read 0;
  - with RISE_EN still 0, DATA=0xFF after 3 ticks and STATUS=0.
REQ-038 Write to DATA: write 0xFFFFFFFF to addr 0 -> DATA is unchanged and reads back the debounced pin value.

Source files
------------

// File: rtl/gpio_in_pkg.sv
// rtl/gpio_in_pkg.sv - register indices shared by gpio_in and the cpu address decoder
package gpio_in_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_RISE_EN = 2'd1,
    REG_FALL_EN = 2'd2,
    REG_STATUS  = 2'd3
  } reg_idx_e;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - one-pin synchronizer and 3-sample debounce with edge pulses
module gpio_debounce #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic tick,
  output logic data,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             hist;
  logic [2:0]             hist_next;

  // Decide on the post-shift history so DATA and the edge pulse land on the tick edge itself.
  assign hist_next = {hist[1:0], sync_q[SYNC_STAGES-1]};
  assign rise      = tick && (&hist_next) && !data;
  assign fall      = tick && !(|hist_next) && data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      hist   <= '0;
      data   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      if (tick) hist <= hist_next;
      if (rise) data <= 1'b1;
      else if (fall) data <= 1'b0;
    end
  end

endmodule

// File: rtl/gpio_in.sv
// rtl/gpio_in.sv - debounced GPIO input block with edge-detect status and level irq
module gpio_in
  import gpio_in_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] pre_cnt;
  logic             tick;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] status_set;
  logic [WIDTH-1:0] status_clr;
  logic [WIDTH-1:0] rd_mux;
  logic             wr;
  logic             rd;

  assign tick = (pre_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    gpio_debounce #(.SYNC_STAGES(SYNC_STAGES)) u_debounce (
      .clk  (clk),
      .reset(reset),
      .pin  (pins[gi]),
      .tick (tick),
      .data (data[gi]),
      .rise (rise[gi]),
      .fall (fall[gi])
    );
  end

  assign wr         = sel && we;
  assign rd         = sel && !we;
  assign status_set = (rise & rise_en) | (fall & fall_en);
  assign status_clr = (wr && addr == REG_STATUS) ? wdata : '0;

  always_comb begin
    rd_mux = '0;
    unique case (reg_idx_e'(addr))
      REG_DATA:    rd_mux = data;
      REG_RISE_EN: rd_mux = rise_en;
      REG_FALL_EN: rd_mux = fall_en;
      REG_STATUS:  rd_mux = status;
    endcase
  end

  // Edge sets are OR-ed in after the W1C mask so a simultaneous set beats the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
      rdata   <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr && addr == REG_RISE_EN) rise_en <= wdata;
      if (wr && addr == REG_FALL_EN) fall_en <= wdata;
      status <= (status & ~status_clr) | status_set;
      if (rd) rdata <= rd_mux;
      irq <= |status;
    end
  end

endmodule

// File: tb/tb_gpio_in.sv
// tb/tb_gpio_in.sv - scoreboard bench for gpio_in with directed vectors
module tb_gpio_in;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int TDIV  = 4;
  localparam int SETTLE = SYNC + 3 * TDIV;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] pins = '0;
  logic             sel = 1'b0;
  logic             we = 1'b0;
  logic [1:0]       addr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  exp_t rd_q[$];
  exp_t obs_q[$];
  bit   rd_pend = 1'b0;
  int   m_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  gpio_in #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TICK_DIV(TDIV)) dut (
    .clk  (clk),
    .reset(reset),
    .pins (pins),
    .sel  (sel),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Prescaler model: m_cnt==0 just after a non-reset edge means that edge carried the tick.
  always @(posedge clk) begin
    if (!reset) m_cnt = 0;
    else m_cnt = (m_cnt == TDIV - 1) ? 0 : m_cnt + 1;
  end

  always @(posedge clk) rd_pend <= sel && !we && reset;

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    if (rd_pend) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read rdata=%h required=none", rdata);
      end else begin
        e = rd_q.pop_front();
        if (rdata !== e.exp) begin
          errors++;
          $display("FAIL %s rdata=%h required=%h", e.name, rdata, e.exp);
        end
      end
    end
    while (obs_q.size() != 0) begin
      e = obs_q.pop_front();
      case (e.sig)
        0:       act = {31'd0, irq};
        1:       act = rdata;
        default: act = rd_q.size();
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b0; addr = a;
    e.name = name; e.sig = 0; e.exp = exp;
    rd_q.push_back(e);
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic observe(input string name, input int sig, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.sig = sig; e.exp = exp;
    obs_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    wait_cycles(3);
    observe("reset_rdata", 1, 32'h0);
    observe("reset_irq", 0, 32'h0);
    reset = 1'b1;
    bus_read(2'd0, 32'h0, "reset_data");
    bus_read(2'd3, 32'h0, "reset_status");

    bus_write(2'd1, 32'h0000_000F);
    bus_read(2'd1, 32'h0000_000F, "readback_rise_en");
    bus_read(2'd0, 32'h0, "readback_data");
    bus_read(2'd2, 32'h0, "readback_fall_en");

    pins = 32'h1;
    wait_cycles(SETTLE);
    bus_read(2'd0, 32'h1, "rise_data");
    bus_read(2'd3, 32'h1, "rise_status");
    observe("rise_irq", 0, 32'h1);

    bus_write(2'd3, 32'h1);
    bus_read(2'd3, 32'h0, "clear_status");
    pins[3] = 1'b1;
    wait_cycles(2 * TDIV);
    pins[3] = 1'b0;
    wait_cycles(20);
    bus_read(2'd0, 32'h1, "glitch_data");
    bus_read(2'd3, 32'h0, "glitch_status");
    observe("glitch_irq", 0, 32'h0);

    // Drop pin 0 right after a tick edge; DATA falls exactly 3*TDIV edges later.
    bus_write(2'd2, 32'h1);
    do begin @(posedge clk); #1; end while (m_cnt != 0);
    pins[0] = 1'b0;
    wait_cycles(3 * TDIV - 1);
    sel = 1'b1; we = 1'b1; addr = 2'd3; wdata = 32'h1;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
    bus_read(2'd0, 32'h0, "race_data");
    bus_read(2'd3, 32'h1, "race_status_set_wins");
    bus_write(2'd3, 32'h1);
    observe("w1c_irq_lag", 0, 32'h1);
    wait_cycles(1);
    observe("w1c_irq_clear", 0, 32'h0);
    bus_read(2'd3, 32'h0, "w1c_status");

    bus_write(2'd1, 32'h1);
    pins = 32'hFF;
    wait_cycles(SETTLE);
    bus_read(2'd0, 32'hFF, "pre_reset_data");
    bus_read(2'd3, 32'h1, "pre_reset_status");
    reset = 1'b0;
    wait_cycles(1);
    reset = 1'b1;
    observe("midreset_rdata", 1, 32'h0);
    observe("midreset_irq", 0, 32'h0);
    bus_read(2'd0, 32'h0, "midreset_data");
    bus_read(2'd1, 32'h0, "midreset_rise_en");
    bus_read(2'd2, 32'h0, "midreset_fall_en");
    bus_read(2'd3, 32'h0, "midreset_status");
    wait_cycles(SETTLE);
    bus_read(2'd0, 32'hFF, "post_reset_data");
    bus_read(2'd3, 32'h0, "post_reset_status");
    observe("post_reset_irq", 0, 32'h0);

    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, 32'hFF, "data_write_ignored");
    addr = 2'd1;
    wait_cycles(3);
    observe("rdata_hold", 1, 32'hFF);

    wait_cycles(2);
    observe("scoreboard_drained", 2, 32'h0);
    wait_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
